// File: rtl/mux_scan_n_1_if.sv
// Bus bundle for mux_scan_n_1: channel data and controls in, registered result out.
// Signal map: i_data=I, i_sel=S, i_en=E, i_mode=MODE, i_hold=HOLD,
//             o_y=Y, o_ch=CH, o_valid=VALID, o_wrap=WRAP.
interface mux_scan_n_1_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] i_data;
    logic [SEL_W-1:0]          i_sel;
    logic                      i_en;
    logic                      i_mode;
    logic                      i_hold;
    logic [WIDTH-1:0]          o_y;
    logic [SEL_W-1:0]          o_ch;
    logic                      o_valid;
    logic                      o_wrap;

    modport master (
        output i_data, i_sel, i_en, i_mode, i_hold,
        input  o_y, o_ch, o_valid, o_wrap
    );

    modport slave (
        input  i_data, i_sel, i_en, i_mode, i_hold,
        output o_y, o_ch, o_valid, o_wrap
    );
endinterface

// File: rtl/mux_scan_n_1.sv
// N:1 enabled mux with registered output and an auto-scan sequencer that presents
// each channel for DWELL cycles, tagging the output with its source channel.
module mux_scan_n_1 #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DWELL    = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    mux_scan_n_1_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {StIdle, StManual, StScan} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   w_y_nxt;
    logic [SEL_W-1:0]   r_ch;
    logic [SEL_W-1:0]   w_ch_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_wrap;
    logic               w_wrap_nxt;
    logic               w_last_ch;

    assign w_last_ch = (r_ch == SEL_W'(CHANNELS - 1));

    // State is simply the mode requested at this edge.
    always_comb begin
        w_state_nxt = StIdle;
        if (bus.i_en) begin
            w_state_nxt = bus.i_mode ? StScan : StManual;
        end
    end

    // Next channel tag, dwell count, valid and wrap for the state being entered.
    always_comb begin
        w_ch_nxt    = r_ch;
        w_cnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_wrap_nxt  = 1'b0;
        case (w_state_nxt)
            StManual: begin
                // Out-of-range selects (non power-of-two CHANNELS) keep CH and drop valid.
                if (32'(bus.i_sel) < CHANNELS) begin
                    w_ch_nxt    = bus.i_sel;
                    w_valid_nxt = 1'b1;
                end
            end
            StScan: begin
                w_valid_nxt = 1'b1;
                if (r_state != StScan) begin
                    // Entry edge: present current CH with a fresh dwell.
                    w_cnt_nxt = '0;
                end else if (bus.i_hold) begin
                    w_cnt_nxt = r_cnt;
                end else if (r_cnt == CNT_W'(DWELL - 1)) begin
                    w_ch_nxt   = w_last_ch ? '0 : r_ch + SEL_W'(1);
                    w_wrap_nxt = w_last_ch;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Data mux on the new channel tag so Y and CH always move together; never indexes out of range.
    always_comb begin
        w_y_nxt = '0;
        if (w_valid_nxt) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                if (w_ch_nxt == SEL_W'(k)) begin
                    w_y_nxt = bus.i_data[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Output and sequencer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_y     <= '0;
            r_ch    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_y     <= w_y_nxt;
            r_ch    <= w_ch_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign bus.o_y     = r_y;
    assign bus.o_ch    = r_ch;
    assign bus.o_valid = r_valid;
    assign bus.o_wrap  = r_wrap;
endmodule

// File: tb/tb_mux_scan_n_1.sv
// Bench for mux_scan_n_1: two instances (4ch/dwell 4 and 3ch/dwell 1) checked every cycle
// against a scan-position model, plus hand-computed expectations per directed step.
module tb_mux_scan_n_1;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic        hold = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [31:0] data_a = {8'h44, 8'h33, 8'h22, 8'h11};
    logic [23:0] data_b = {8'h33, 8'h22, 8'h11};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux_scan_n_1_if #(.WIDTH(8), .CHANNELS(4)) bus_a ();
    mux_scan_n_1_if #(.WIDTH(8), .CHANNELS(3)) bus_b ();

    assign bus_a.i_data = data_a;
    assign bus_a.i_sel  = sel;
    assign bus_a.i_en   = en;
    assign bus_a.i_mode = mode;
    assign bus_a.i_hold = hold;
    assign bus_b.i_data = data_b;
    assign bus_b.i_sel  = sel;
    assign bus_b.i_en   = en;
    assign bus_b.i_mode = mode;
    assign bus_b.i_hold = hold;

    mux_scan_n_1 #(.WIDTH(8), .CHANNELS(4), .DWELL(4)) u_a (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus_a)
    );

    mux_scan_n_1 #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) u_b (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus_b)
    );

    // Model: scan position = steady non-hold edges since entry; channel = base + pos/dwell.
    logic [7:0] m_y    [2];
    int         m_ch   [2];
    bit         m_v    [2];
    bit         m_w    [2];
    bit         m_scan [2];
    int         m_base [2];
    int         m_pos  [2];

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            m_y[i] = 8'h00; m_ch[i] = 0; m_v[i] = 1'b0; m_w[i] = 1'b0;
            m_scan[i] = 1'b0; m_base[i] = 0; m_pos[i] = 0;
        end
    endtask

    task automatic mstep(input int idx, input int nch, input int dwell, input logic [31:0] data);
        int nc;
        if (!en) begin
            m_y[idx] = 8'h00; m_v[idx] = 1'b0; m_w[idx] = 1'b0; m_scan[idx] = 1'b0;
        end else if (!mode) begin
            m_scan[idx] = 1'b0;
            m_w[idx] = 1'b0;
            if (int'(sel) < nch) begin
                m_ch[idx] = int'(sel);
                m_v[idx]  = 1'b1;
                m_y[idx]  = data[m_ch[idx]*8 +: 8];
            end else begin
                m_v[idx] = 1'b0;
                m_y[idx] = 8'h00;
            end
        end else if (!m_scan[idx]) begin
            m_scan[idx] = 1'b1;
            m_base[idx] = m_ch[idx];
            m_pos[idx]  = 0;
            m_v[idx]    = 1'b1;
            m_w[idx]    = 1'b0;
            m_y[idx]    = data[m_ch[idx]*8 +: 8];
        end else begin
            if (!hold) m_pos[idx] = m_pos[idx] + 1;
            nc = (m_base[idx] + m_pos[idx] / dwell) % nch;
            m_w[idx]  = !hold && (m_pos[idx] % dwell == 0) && (nc == 0);
            m_ch[idx] = nc;
            m_v[idx]  = 1'b1;
            m_y[idx]  = data[nc*8 +: 8];
        end
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mreset();
            end else begin
                mstep(0, 4, 4, data_a);
                mstep(1, 3, 1, {8'h00, data_b});
            end
        end
    end

    // Hand-computed expectations for the outputs of the most recent edge.
    bit         lit_on [2];
    string      lit_nm [2];
    logic [7:0] lit_y  [2];
    int         lit_ch [2];
    bit         lit_v  [2];
    bit         lit_w  [2];

    task automatic exp_out(input int idx, input string nm, input logic [7:0] y, input int ch,
                           input bit v, input bit w);
        lit_on[idx] = 1'b1;
        lit_nm[idx] = nm;
        lit_y[idx]  = y;
        lit_ch[idx] = ch;
        lit_v[idx]  = v;
        lit_w[idx]  = w;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        lit_on[0] = 1'b0;
        lit_on[1] = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Single compare process, sampling at the falling edge.
    initial begin
        logic [7:0] y;
        int         ch;
        logic       v;
        logic       w;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (i == 0) begin
                    y = bus_a.o_y; ch = 32'(bus_a.o_ch); v = bus_a.o_valid; w = bus_a.o_wrap;
                end else begin
                    y = bus_b.o_y; ch = 32'(bus_b.o_ch); v = bus_b.o_valid; w = bus_b.o_wrap;
                end
                chk($sformatf("model%0d.y", i), 32'(y), 32'(m_y[i]));
                chk($sformatf("model%0d.ch", i), ch, m_ch[i]);
                chk($sformatf("model%0d.valid", i), 32'(v), 32'(m_v[i]));
                chk($sformatf("model%0d.wrap", i), 32'(w), 32'(m_w[i]));
                if (lit_on[i]) begin
                    chk({lit_nm[i], ".y"}, 32'(y), 32'(lit_y[i]));
                    chk({lit_nm[i], ".ch"}, ch, lit_ch[i]);
                    chk({lit_nm[i], ".valid"}, 32'(v), 32'(lit_v[i]));
                    chk({lit_nm[i], ".wrap"}, 32'(w), 32'(lit_w[i]));
                end
            end
        end
    end

    initial begin
        // Reset state, then idle.
        step();
        exp_out(0, "rstA", 8'h00, 0, 1'b0, 1'b0);
        exp_out(1, "rstB", 8'h00, 0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        exp_out(0, "idleA", 8'h00, 0, 1'b0, 1'b0);

        // Scan from idle: A shows each channel 4 cycles; B advances every cycle.
        en = 1'b1; mode = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            exp_out(0, $sformatf("scanA%0d", k), 8'(8'h11 * (k / 4 + 1)), k / 4, 1'b1, 1'b0);
            if (k < 7) begin
                exp_out(1, $sformatf("scanB%0d", k), 8'(8'h11 * (k % 3 + 1)), k % 3, 1'b1,
                        (k > 0) && (k % 3 == 0));
            end
        end
        step();
        exp_out(0, "wrapA", 8'h11, 0, 1'b1, 1'b1);
        step();
        exp_out(0, "wrapA_end", 8'h11, 0, 1'b1, 1'b0);
        step();
        exp_out(0, "ch0_c3", 8'h11, 0, 1'b1, 1'b0);
        step();
        exp_out(0, "ch0_c4", 8'h11, 0, 1'b1, 1'b0);
        step();
        exp_out(0, "ch1_c1", 8'h22, 1, 1'b1, 1'b0);

        // Hold for 3 edges from the 2nd cycle of ch1; live data tracked.
        hold = 1'b1;
        step();
        exp_out(0, "hold1", 8'h22, 1, 1'b1, 1'b0);
        step();
        exp_out(0, "hold2", 8'h22, 1, 1'b1, 1'b0);
        data_a[15:8] = 8'hA5;
        step();
        exp_out(0, "hold3", 8'hA5, 1, 1'b1, 1'b0);
        hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            exp_out(0, $sformatf("ch1_post%0d", k), 8'hA5, 1, 1'b1, 1'b0);
        end
        step();
        exp_out(0, "ch2_c1", 8'h33, 2, 1'b1, 1'b0);
        step();
        exp_out(0, "ch2_c2", 8'h33, 2, 1'b1, 1'b0);

        // Mode switch mid-dwell to manual S=0, then back to scan.
        mode = 1'b0; sel = 2'd0;
        step();
        exp_out(0, "man0", 8'h11, 0, 1'b1, 1'b0);
        mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            exp_out(0, $sformatf("rescan%0d", k), 8'h11, 0, 1'b1, 1'b0);
        end
        step();
        exp_out(0, "rescan_ch1", 8'hA5, 1, 1'b1, 1'b0);

        // Manual select then disable.
        data_a[15:8] = 8'h22;
        mode = 1'b0; sel = 2'd2;
        step();
        exp_out(0, "man2", 8'h33, 2, 1'b1, 1'b0);
        en = 1'b0;
        step();
        exp_out(0, "dis", 8'h00, 2, 1'b0, 1'b0);

        // Async reset mid-scan, checked before the next clock.
        en = 1'b1; mode = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        exp_out(0, "asyncA", 8'h00, 0, 1'b0, 1'b0);
        exp_out(1, "asyncB", 8'h00, 0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        exp_out(0, "postrstA", 8'h11, 0, 1'b1, 1'b0);
        exp_out(1, "postrstB", 8'h11, 0, 1'b1, 1'b0);

        // Manual on the 3-channel instance, including out-of-range S=3.
        mode = 1'b0; sel = 2'd1;
        step();
        exp_out(1, "manB1", 8'h22, 1, 1'b1, 1'b0);
        sel = 2'd3;
        step();
        exp_out(0, "manA3", 8'h44, 3, 1'b1, 1'b0);
        exp_out(1, "manB3", 8'h00, 1, 1'b0, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
